// File: rtl/stream_mux_rr.sv
// N-channel stream multiplexer with a single registered output slot.
// The channel is chosen by an external select (MODE=0) or by a round-robin
// pointer that starts its search just past the last granted channel (MODE=1).
module stream_mux_rr #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned N      = 4,
    parameter int unsigned MODE   = 1,
    localparam int unsigned CHAN_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        in_valid,
    input  logic [N*WIDTH-1:0]  in_data,
    output logic [N-1:0]        in_ready,
    input  logic [CHAN_W-1:0]   sel,
    output logic                out_valid,
    output logic [WIDTH-1:0]    out_data,
    output logic [CHAN_W-1:0]   out_chan,
    input  logic                out_ready
);

    logic              load_en;
    logic [N-1:0]      gnt;
    logic              gnt_any;
    logic [CHAN_W-1:0] gnt_idx;
    logic [WIDTH-1:0]  gnt_data;
    logic [CHAN_W-1:0] ptr_q;
    logic [CHAN_W-1:0] ptr_d;

    // The output slot can take a new word when empty or being drained now.
    assign load_en = !out_valid || out_ready;

    // Ready is gated by reset so nothing is offered while the block is held.
    assign in_ready = rst_n ? (gnt & {N{load_en}}) : '0;

    // Grant selection: one-hot or zero, recomputed every cycle.
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (MODE == 0) begin
            // An out-of-range select matches no channel and yields no grant.
            for (int i = 0; i < int'(N); i++) begin
                if (sel == CHAN_W'(i) && in_valid[i]) begin
                    gnt[i]  = 1'b1;
                    gnt_any = 1'b1;
                    gnt_idx = CHAN_W'(i);
                end
            end
        end else begin
            // Two passes implement the wrapping search: ptr..N-1, then 0..ptr-1.
            for (int i = 0; i < int'(N); i++) begin
                if (!gnt_any && in_valid[i] && CHAN_W'(i) >= ptr_q) begin
                    gnt[i]  = 1'b1;
                    gnt_any = 1'b1;
                    gnt_idx = CHAN_W'(i);
                end
            end
            for (int i = 0; i < int'(N); i++) begin
                if (!gnt_any && in_valid[i] && CHAN_W'(i) < ptr_q) begin
                    gnt[i]  = 1'b1;
                    gnt_any = 1'b1;
                    gnt_idx = CHAN_W'(i);
                end
            end
        end
    end

    // Data mux driven by the one-hot grant.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (gnt[i]) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Pointer advances past the granted channel only on an actual transfer.
    always_comb begin
        ptr_d = ptr_q;
        if (MODE == 1 && load_en && gnt_any) begin
            // Explicit wrap keeps ptr below N for non-power-of-two N.
            ptr_d = (gnt_idx == CHAN_W'(N - 1)) ? '0 : gnt_idx + CHAN_W'(1);
        end
    end

    // Output register and arbitration pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr_q     <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (load_en) begin
                out_valid <= gnt_any;
                if (gnt_any) begin
                    out_data <= gnt_data;
                    out_chan <= gnt_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: directed cases on a 4-channel round-robin and a
// 3-channel fixed-select instance, then a random soak of a 5-channel
// round-robin instance against a behavioural model and per-channel scoreboard.
module tb_stream_mux_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // Round-robin instance, N=4, WIDTH=8.
    logic [3:0]  a_in_valid, a_in_ready;
    logic [31:0] a_in_data;
    logic [1:0]  a_sel, a_out_chan;
    logic        a_out_valid, a_out_ready;
    logic [7:0]  a_out_data;

    // Fixed-select instance, N=3, WIDTH=8.
    logic [2:0]  f_in_valid, f_in_ready;
    logic [23:0] f_in_data;
    logic [1:0]  f_sel, f_out_chan;
    logic        f_out_valid, f_out_ready;
    logic [7:0]  f_out_data;

    // Soak instance, N=5, WIDTH=16 (data = {channel, sequence}).
    logic [4:0]  s_in_valid, s_in_ready;
    logic [79:0] s_in_data;
    logic [2:0]  s_sel, s_out_chan;
    logic        s_out_valid, s_out_ready;
    logic [15:0] s_out_data;

    stream_mux_rr #(.WIDTH(8), .N(4), .MODE(1)) u_rr4 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_data(a_in_data),
        .in_ready(a_in_ready), .sel(a_sel), .out_valid(a_out_valid),
        .out_data(a_out_data), .out_chan(a_out_chan), .out_ready(a_out_ready)
    );

    stream_mux_rr #(.WIDTH(8), .N(3), .MODE(0)) u_fix3 (
        .clk(clk), .rst_n(rst_n), .in_valid(f_in_valid), .in_data(f_in_data),
        .in_ready(f_in_ready), .sel(f_sel), .out_valid(f_out_valid),
        .out_data(f_out_data), .out_chan(f_out_chan), .out_ready(f_out_ready)
    );

    stream_mux_rr #(.WIDTH(16), .N(5), .MODE(1)) u_rr5 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_data(s_in_data),
        .in_ready(s_in_ready), .sel(s_sel), .out_valid(s_out_valid),
        .out_data(s_out_data), .out_chan(s_out_chan), .out_ready(s_out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: first valid channel at or after p, modulo 5.
    function automatic int rr_pick(input int p, input logic [4:0] v);
        for (int k = 0; k < 5; k++) begin
            if (v[(p + k) % 5]) return (p + k) % 5;
        end
        return -1;
    endfunction

    // Soak model state.
    bit          m_valid;
    logic [15:0] m_data;
    int          m_chan;
    int          m_ptr;
    int          seq      [5];
    int          wait_cnt [5];
    logic [15:0] sb       [5][$];

    task automatic soak_cycle(input bit gen, input bit rdy_rand);
        bit          load;
        int          g;
        logic [15:0] exp_word;
        for (int i = 0; i < 5; i++) begin
            if (!s_in_valid[i] && gen && $urandom_range(0, 2) != 0) begin
                s_in_valid[i]          = 1'b1;
                s_in_data[i*16 +: 16]  = {8'(i), 8'(seq[i])};
            end
        end
        s_out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        check("s_out_valid", 32'(s_out_valid), 32'(m_valid));
        if (m_valid) begin
            check("s_out_data", 32'(s_out_data), 32'(m_data));
            check("s_out_chan", 32'(s_out_chan), 32'(m_chan));
        end
        load = !m_valid || s_out_ready;
        g    = load ? rr_pick(m_ptr, s_in_valid) : -1;
        check("s_in_ready", 32'(s_in_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        if (m_valid && s_out_ready) begin
            if (sb[m_chan].size() == 0) begin
                check("s_no_dup", 32'd1, 32'd0);
            end else begin
                exp_word = sb[m_chan].pop_front();
                check("s_order", 32'(s_out_data), 32'(exp_word));
            end
        end
        if (load) begin
            if (g >= 0) begin
                sb[g].push_back(s_in_data[g*16 +: 16]);
                check("s_fair_wait", 32'(wait_cnt[g] <= 4), 32'd1);
                wait_cnt[g] = 0;
                for (int j = 0; j < 5; j++) begin
                    if (j != g && s_in_valid[j]) wait_cnt[j]++;
                end
                m_valid = 1'b1;
                m_data  = s_in_data[g*16 +: 16];
                m_chan  = g;
                m_ptr   = (g + 1) % 5;
            end else begin
                m_valid = 1'b0;
            end
        end
        tick();
        if (g >= 0) begin
            s_in_valid[g] = 1'b0;
            seq[g]++;
        end
    endtask

    logic [7:0] tbl  [4];
    int         skip [3];

    initial begin
        tbl  = '{8'h10, 8'h21, 8'h32, 8'h43};
        skip = '{3, 1, 3};
        rst_n       = 1'b0;
        a_in_valid  = 4'hf;
        a_in_data   = {8'h43, 8'h32, 8'h21, 8'h10};
        a_sel       = '0;
        a_out_ready = 1'b1;
        f_in_valid  = '0;
        f_in_data   = '0;
        f_sel       = '0;
        f_out_ready = 1'b1;
        s_in_valid  = '0;
        s_in_data   = '0;
        s_sel       = '0;
        s_out_ready = 1'b1;
        m_valid     = 1'b0;
        m_data      = '0;
        m_chan      = 0;
        m_ptr       = 0;
        for (int i = 0; i < 5; i++) begin
            seq[i]      = 0;
            wait_cnt[i] = 0;
        end

        // Reset state, with requests pending.
        #3;
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_data", 32'(a_out_data), 32'd0);
        check("rst_out_chan", 32'(a_out_chan), 32'd0);
        check("rst_in_ready", 32'(a_in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("rr_first_ready", 32'(a_in_ready), 32'b0001);

        // Fairness: all valid, one word per cycle in channel order.
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rr_valid", 32'(a_out_valid), 32'd1);
            check("rr_chan", 32'(a_out_chan), 32'(k % 4));
            check("rr_data", 32'(a_out_data), 32'(tbl[k % 4]));
            check("rr_ready", 32'(a_in_ready), 32'd1 << ((k + 1) % 4));
        end

        // Skip and wrap: only 1 and 3 valid, search starts at 2.
        a_in_valid = 4'b1010;
        #1;
        check("skip_ready0", 32'(a_in_ready), 32'b1000);
        for (int j = 0; j < 3; j++) begin
            tick();
            check("skip_chan", 32'(a_out_chan), 32'(skip[j]));
            check("skip_data", 32'(a_out_data), 32'(tbl[skip[j]]));
            check("skip_ready", 32'(a_in_ready), (skip[j] == 3) ? 32'b0010 : 32'b1000);
        end

        // Backpressure with 0x5A held in the output slot.
        a_in_data[7:0] = 8'h5A;
        a_in_valid     = 4'b0001;
        #1;
        check("bp_load_ready", 32'(a_in_ready), 32'b0001);
        tick();
        check("bp_loaded", 32'(a_out_data), 32'h5A);
        a_out_ready = 1'b0;
        a_in_valid  = 4'hf;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_ready", 32'(a_in_ready), 32'd0);
            check("bp_valid", 32'(a_out_valid), 32'd1);
            check("bp_data", 32'(a_out_data), 32'h5A);
            check("bp_chan", 32'(a_out_chan), 32'd0);
            tick();
        end
        a_out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(a_in_ready), 32'b0010);
        tick();
        check("bp_next_chan", 32'(a_out_chan), 32'd1);
        check("bp_next_data", 32'(a_out_data), 32'h21);
        a_in_valid = 4'b0000;
        tick();
        check("drain_valid", 32'(a_out_valid), 32'd0);

        // Reset mid-stream while a word is held.
        a_in_valid  = 4'hf;
        a_out_ready = 1'b0;
        #1;
        check("mid_ready", 32'(a_in_ready), 32'b0100);
        tick();
        check("mid_held", 32'(a_out_chan), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(a_out_valid), 32'd0);
        check("mid_rst_data", 32'(a_out_data), 32'd0);
        check("mid_rst_chan", 32'(a_out_chan), 32'd0);
        check("mid_rst_ready", 32'(a_in_ready), 32'd0);
        #1;
        rst_n = 1'b1;
        #1;
        check("mid_ptr_cleared", 32'(a_in_ready), 32'b0001);
        a_in_valid  = 4'b0000;
        a_out_ready = 1'b1;
        tick();
        tick();

        // Fixed select, N=3.
        f_in_data  = {8'hA2, 8'hA1, 8'hA0};
        f_in_valid = 3'b111;
        f_sel      = 2'd2;
        #1;
        check("fix_sel2_ready", 32'(f_in_ready), 32'b100);
        tick();
        check("fix_sel2_chan", 32'(f_out_chan), 32'd2);
        check("fix_sel2_data", 32'(f_out_data), 32'hA2);
        check("fix_sel2_valid", 32'(f_out_valid), 32'd1);
        f_sel = 2'd3;
        #1;
        check("fix_oob_ready", 32'(f_in_ready), 32'd0);
        tick();
        check("fix_oob_drain", 32'(f_out_valid), 32'd0);
        f_sel      = 2'd0;
        f_in_valid = 3'b110;
        #1;
        check("fix_sel0_idle", 32'(f_in_ready), 32'd0);
        f_sel = 2'd1;
        #1;
        check("fix_sel1_ready", 32'(f_in_ready), 32'b010);
        tick();
        check("fix_sel1_chan", 32'(f_out_chan), 32'd1);
        check("fix_sel1_data", 32'(f_out_data), 32'hA1);
        f_in_valid = '0;
        tick();

        // Random soak, then drain with the consumer always ready.
        for (int c = 0; c < 1500; c++) soak_cycle(1'b1, 1'b1);
        for (int c = 0; c < 40; c++) soak_cycle(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) check("s_no_loss", 32'(sb[i].size()), 32'd0);
        check("s_empty_end", 32'(s_out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel stream multiplexer with registered output and valid/ready handshakes on every port. It generalises the team's 2:1 select mux from a static combinational choice of two 8-bit words to N channels of WIDTH bits. Channel choice is either externally selected (MODE=0) or round-robin arbitrated (MODE=1). It sits between multiple producer streams and a single consumer, such as a shared bus or FIFO write port.

## Interface
- WIDTH, 8, data width per channel (>=1)
- N, 4, number of input channels (2..16)
- MODE, 1, 0 = fixed select via `sel`, 1 = round-robin arbitration
- CHAN_W, derived = max(1, $clog2(N)), width of channel index (localparam)

- clk  input  1  rising-edge clock, sole clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  N  per-channel valid
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  N  per-channel ready (combinational, one-hot or zero)
- sel  input  CHAN_W  channel select, used only when MODE=0
- out_valid  output  1  registered output valid
- out_data  output  WIDTH  registered output data
- out_chan  output  CHAN_W  index of channel that produced out_data
- out_ready  input  1  consumer ready

## Operation
- Output stage is a single register: out_valid, out_data, out_chan.
- load_en = !out_valid || out_ready (register empty or being drained this cycle).
- Grant vector `gnt` (N bits, at most one set) is computed combinationally each cycle; in_ready = gnt & {N{load_en}}.
- Input transfer on channel i occurs when in_valid[i] && in_ready[i]; the register then loads in_data[i], out_chan <= i, out_valid <= 1.
- If load_en && no grant: out_valid <= 0 (drained, nothing new). If !load_en: register holds all values.
- MODE=0: gnt[sel] = in_valid[sel]; if sel >= N, gnt = 0 (no transfer, never X).
- MODE=1: pointer `ptr` (CHAN_W bits, reset 0). Search channels ptr, ptr+1, ... wrapping modulo N; first with in_valid set is granted. On a transfer from channel i, ptr <= (i+1) mod N. The pointer is unchanged when there is no transfer, including when load_en=0.
- Wrap: a grant to channel N-1 sets ptr to 0. Non-power-of-two N must never produce ptr >= N.
- Requesters must hold in_valid/in_data stable until accepted. The block does not require this for correctness: a grant is recomputed every cycle.
- `sel` is ignored in MODE=1; `ptr` is unused in MODE=0.

## Timing
- Reset (async assert, sync-to-clk deassert by the system): out_valid=0, out_data=0, out_chan=0, ptr=0. in_ready=0 is implied while out_valid=0 only when no in_valid; with rst_n low, in_ready is forced to 0.
- Latency: data accepted at edge t appears on out_data with out_valid=1 after edge t (visible in cycle t+1).
- Throughput: one word per cycle while out_ready=1 and any channel is valid.
- Simultaneous drain and load: with out_valid=1 and out_ready=1 in the same cycle, the old word is consumed and the new word is loaded at the same edge, with no bubble.
- Backpressure: out_valid=1 and out_ready=0 force all in_ready to 0. out_data and out_chan must not change until the handshake completes.
- Reset mid-transfer: the held output word is discarded. out_valid drops immediately on rst_n low, without waiting for clk.
- No combinational path from out_ready to out_data. in_ready depends combinationally on out_ready, in_valid, sel and ptr.

## Test plan
- Reset: assert rst_n=0 mid-stream with out_valid=1. Required: out_valid, out_data, out_chan and ptr read 0 before the next clk edge, and in_ready=0.
- RR fairness, N=4, WIDTH=8, all in_valid=1, out_ready=1, in_data = 0x10,0x21,0x32,0x43. Required: out_chan sequence 0,1,2,3,0,1 with out_data 0x10,0x21,0x32,0x43,… at one word per cycle.
- RR skip and wrap: only channels 1 and 3 valid, ptr=2. Required: grants 3, then 1, then 3, with ptr values 0, 2, 0.
- Backpressure: hold out_ready=0 for 5 cycles with out_valid=1 and out_data=0x5A. Required: out_data stays 0x5A, in_ready=0 throughout and ptr is unchanged. When out_ready rises, the next word loads on the same edge.
- Fixed mode, MODE=0, N=3: sel=2 with in_valid=3'b111 gives out_chan=2. sel=3 (out of range) gives in_ready=0 and out_valid falling to 0 after a drain.
- Random soak with N=5 and random valid/ready: a scoreboard checks per-channel order, no loss or duplication, and that each continuously-valid channel waits at most N-1 grants between its own grants.
